// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready on both sides.
// MUL is radix-2 Booth and DIV is restoring division, one step per cycle.
module seq_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [3:0]           opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 carry,
  output logic                 div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_RSH = 4'd4;
  localparam logic [3:0] OP_LSH = 4'd5;
  localparam logic [3:0] OP_BOR = 4'd6;
  localparam logic [3:0] OP_BAN = 4'd7;

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  state_t               state_q;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     m_q;
  logic [WIDTH:0]       acc_q;
  logic [WIDTH-1:0]     mq_q;
  logic                 qm1_q;
  logic [SHW-1:0]       cnt_q;
  logic [2*WIDTH-1:0]   out_q;
  logic                 carry_q;
  logic                 dbz_q;

  logic [WIDTH:0]       add_s;
  logic [WIDTH:0]       sub_s;
  logic [WIDTH-1:0]     shr;
  logic [WIDTH-1:0]     shl;
  logic [2*WIDTH-1:0]   quick_out;
  logic                 quick_c;
  logic                 quick_z;
  logic                 go_exec;

  logic [WIDTH:0]       m_ext;
  logic [WIDTH:0]       bsum;
  logic [WIDTH:0]       b_acc;
  logic [WIDTH-1:0]     b_mq;
  logic [WIDTH:0]       r_sh;
  logic [WIDTH:0]       diff;
  logic [WIDTH:0]       d_acc;
  logic [WIDTH-1:0]     d_mq;

  logic [WIDTH:0]       acc_d;
  logic [WIDTH-1:0]     mq_d;
  logic [2*WIDTH-1:0]   fin_d;

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out         = out_q;
  assign carry       = carry_q;
  assign div_by_zero = dbz_q;

  // Single-cycle ops are evaluated on the accept edge itself.
  always_comb begin
    add_s = {1'b0, a} + {1'b0, b};
    sub_s = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    shr   = a >> b[SHW-1:0];
    shl   = a << b[SHW-1:0];
    quick_out = '0;
    quick_c   = 1'b0;
    quick_z   = 1'b0;
    unique case (opcode)
      OP_ADD: begin
        quick_out = {{(WIDTH-1){1'b0}}, add_s};
        quick_c   = add_s[WIDTH];
      end
      OP_SUB: begin
        quick_out = {{(WIDTH-1){1'b0}}, sub_s};
        quick_c   = sub_s[WIDTH];
      end
      OP_DIV: begin
        quick_out = {a, {WIDTH{1'b1}}};
        quick_z   = 1'b1;
      end
      OP_RSH: quick_out = {{WIDTH{1'b0}}, shr};
      OP_LSH: quick_out = {{WIDTH{1'b0}}, shl};
      OP_BOR: quick_out = {{WIDTH{1'b0}}, a | b};
      OP_BAN: quick_out = {{WIDTH{1'b0}}, a & b};
      default: quick_out = '0;
    endcase
    go_exec = (opcode == OP_MUL) ||
              ((opcode == OP_DIV) && (b != '0));
  end

  // Booth step: add/sub the sign-extended multiplicand, then
  // arithmetic shift of {acc, mq, qm1}. acc has a guard bit so that
  // subtracting the most negative multiplicand cannot overflow.
  always_comb begin
    m_ext = {m_q[WIDTH-1], m_q};
    unique case ({mq_q[0], qm1_q})
      2'b01:   bsum = acc_q + m_ext;
      2'b10:   bsum = acc_q - m_ext;
      default: bsum = acc_q;
    endcase
    b_acc = {bsum[WIDTH], bsum[WIDTH:1]};
    b_mq  = {bsum[0], mq_q[WIDTH-1:1]};
  end

  // Restoring step: shift in the next dividend bit, trial-subtract.
  always_comb begin
    r_sh = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    diff = r_sh - {1'b0, m_q};
    if (diff[WIDTH]) begin
      d_acc = r_sh;
      d_mq  = {mq_q[WIDTH-2:0], 1'b0};
    end else begin
      d_acc = diff;
      d_mq  = {mq_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    if (op_q == OP_MUL) begin
      acc_d = b_acc;
      mq_d  = b_mq;
    end else begin
      acc_d = d_acc;
      mq_d  = d_mq;
    end
    fin_d = {acc_d[WIDTH-1:0], mq_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q  <= opcode;
            m_q   <= b;
            acc_q <= '0;
            mq_q  <= a;
            qm1_q <= 1'b0;
            cnt_q <= '0;
            if (go_exec) begin
              state_q <= EXEC;
            end else begin
              out_q   <= quick_out;
              carry_q <= quick_c;
              dbz_q   <= quick_z;
              state_q <= DONE;
            end
          end
        end
        EXEC: begin
          acc_q <= acc_d;
          mq_q  <= mq_d;
          qm1_q <= mq_q[0];
          cnt_q <= cnt_q + SHW'(1);
          if (cnt_q == LAST) begin
            out_q   <= fin_d;
            carry_q <= 1'b0;
            dbz_q   <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed + random bench for seq_alu (WIDTH=32).
// Expected results go through a scoreboard queue.
module tb_seq_alu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out;
  logic        carry;
  logic        div_by_zero;

  typedef struct {
    logic [63:0] o;
    logic        c;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .opcode      (opcode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .carry       (carry),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [31:0] xa,
                                 input logic [31:0] xb);
    exp_t e;
    logic signed [63:0] p;
    e.o = '0;
    e.c = 1'b0;
    e.z = 1'b0;
    case (op)
      4'd0: begin
        e.o = {32'b0, xa} + {32'b0, xb};
        e.c = e.o[32];
      end
      4'd1: begin
        e.c = (xa >= xb);
        e.o = {31'b0, e.c, xa - xb};
      end
      4'd2: begin
        p = $signed({{32{xa[31]}}, xa}) * $signed({{32{xb[31]}}, xb});
        e.o = p;
      end
      4'd3: begin
        if (xb == 0) begin
          e.o = {xa, 32'hFFFF_FFFF};
          e.z = 1'b1;
        end else begin
          e.o = {xa % xb, xa / xb};
        end
      end
      4'd4: e.o = {32'b0, xa >> xb[4:0]};
      4'd5: e.o = {32'b0, xa << xb[4:0]};
      4'd6: e.o = {32'b0, xa | xb};
      4'd7: e.o = {32'b0, xa & xb};
      default: e.o = '0;
    endcase
    return e;
  endfunction

  task automatic push(input logic [63:0] eo,
                      input logic ec, input logic ez);
    exp_t e;
    e.o = eo;
    e.c = ec;
    e.z = ez;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, got %h", tag, out);
    end else begin
      e = sb.pop_front();
      chk({tag, ".out"}, out, e.o);
      chk({tag, ".carry"}, 64'(carry), 64'(e.c));
      chk({tag, ".dbz"}, 64'(div_by_zero), 64'(e.z));
    end
  endtask

  // Issue one op with out_ready=1, check latency, result and return to idle.
  task automatic issue(input string tag, input logic [3:0] op,
                       input logic [31:0] xa, input logic [31:0] xb,
                       input int elat);
    int lat;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a = xa;
    b = xb;
    opcode = op;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    opcode = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(elat));
    pop_cmp(tag);
    @(posedge clk);
    #1;
    chk({tag, ".idle_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".idle_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    exp_t e;
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          rl;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.out", out, 64'd0);
    chk("reset.valid", 64'(out_valid), 64'd0);
    chk("reset.carry", 64'(carry), 64'd0);
    chk("reset.dbz", 64'(div_by_zero), 64'd0);
    chk("reset.ready", 64'(in_ready), 64'd1);

    push(64'h0000_0001_0000_0000, 1'b1, 1'b0);
    issue("add_ovf", 4'd0, 32'hFFFF_FFFF, 32'd1, 1);
    push(64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0);
    issue("sub_borrow", 4'd1, 32'd5, 32'd7, 1);
    push(64'h0000_0001_0000_0002, 1'b1, 1'b0);
    issue("sub_nob", 4'd1, 32'd7, 32'd5, 1);
    push(64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0);
    issue("mul_neg", 4'd2, 32'hFFFF_FFFD, 32'd7, 33);
    push(64'h4000_0000_0000_0000, 1'b0, 1'b0);
    issue("mul_min", 4'd2, 32'h8000_0000, 32'h8000_0000, 33);
    push({32'd2, 32'd14}, 1'b0, 1'b0);
    issue("div", 4'd3, 32'd100, 32'd7, 33);
    push({32'd100, 32'hFFFF_FFFF}, 1'b0, 1'b1);
    issue("div0", 4'd3, 32'd100, 32'd0, 1);
    push(64'h0000_0000_0000_0008, 1'b0, 1'b0);
    issue("rsh", 4'd4, 32'h8000_0000, 32'hFFFF_FFFC, 1);
    push(64'd0, 1'b0, 1'b0);
    issue("reserved", 4'd12, 32'hDEAD_BEEF, 32'h1234_5678, 1);

    // Backpressure: BAN result held while a BOR waits at the input.
    out_ready = 1'b0;
    push(64'h0000_0000_00F0_1200, 1'b0, 1'b0);
    in_valid = 1'b1;
    a = 32'hF0F0_1234;
    b = 32'h0FF0_FF00;
    opcode = 4'd7;
    @(posedge clk);
    #1;
    chk("bp.valid0", 64'(out_valid), 64'd1);
    a = 32'h1111_0000;
    b = 32'h0000_2222;
    opcode = 4'd6;
    push(64'h0000_0000_1111_2222, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp.valid", 64'(out_valid), 64'd1);
      chk("bp.ready", 64'(in_ready), 64'd0);
      chk("bp.out", out, 64'h0000_0000_00F0_1200);
      chk("bp.carry", 64'(carry), 64'd0);
    end
    pop_cmp("bp.ban");
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.drain_valid", 64'(out_valid), 64'd0);
    chk("bp.drain_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp.bor_valid", 64'(out_valid), 64'd1);
    pop_cmp("bp.bor");
    @(posedge clk);
    #1;
    chk("bp.end_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of a MUL, at iteration 10.
    in_valid = 1'b1;
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    opcode = 4'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid.busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid.valid", 64'(out_valid), 64'd0);
    chk("rst_mid.out", out, 64'd0);
    chk("rst_mid.ready", 64'(in_ready), 64'd1);
    push(64'h10, 1'b0, 1'b0);
    issue("lsh", 4'd5, 32'd1, 32'h24, 1);

    for (int i = 0; i < 12; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rop = 4'd2;
      if (i % 4 == 1) rop = 4'd3;
      if (i == 5) rb = 32'd0;
      if (i == 9) rb = 32'd3;
      rl = ((rop == 4'd2) || (rop == 4'd3 && rb != 0)) ? 33 : 1;
      e = model(rop, ra, rb);
      push(e.o, e.c, e.z);
      issue($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, rl);
    end

    chk("sb.empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
